// File: rtl/add_tree_pkg.sv
// ----------------------------------------------------------------------------
// add_tree_pkg
// Shared sizing helpers for the pipelined adder tree:
//   half_ceil   - element count after one pairwise level (ceil(n/2))
//   tree_levels - number of pairwise levels needed to reduce n values to one
//   level_count - element count entering level k of an n-input tree
//   level_width - operand width at level k (grows by one bit per level)
// ----------------------------------------------------------------------------
package add_tree_pkg;

    function automatic int unsigned half_ceil(input int unsigned n);
        return (n + 32'd1) / 32'd2;
    endfunction

    function automatic int unsigned tree_levels(input int unsigned n);
        int unsigned cnt;
        int unsigned lv;
        cnt = n;
        lv  = 32'd0;
        while (cnt > 32'd1) begin
            cnt = half_ceil(cnt);
            lv  = lv + 32'd1;
        end
        return lv;
    endfunction

    function automatic int unsigned level_count(input int unsigned n, input int unsigned k);
        int unsigned cnt;
        cnt = n;
        for (int unsigned i = 32'd0; i < k; i++) begin
            cnt = half_ceil(cnt);
        end
        return cnt;
    endfunction

    function automatic int unsigned level_width(input int unsigned w, input int unsigned k);
        return w + k;
    endfunction

endpackage

// File: rtl/add_tree_level.sv
// ----------------------------------------------------------------------------
// add_tree_level
// One registered level of the adder tree. Adjacent inputs (2i, 2i+1) are
// added into a result one bit wider; an odd trailing input is zero-extended
// and passed through. The matching valid bit travels with the data.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (clears data and valid)
//   en        - advance enable; all state holds when low
//   in_i      - IN_CNT operands of IN_W bits
//   valid_i   - valid bit accompanying in_i
//   out_o     - ceil(IN_CNT/2) results of IN_W+1 bits (registered)
//   valid_o   - valid bit accompanying out_o (registered)
// ----------------------------------------------------------------------------
module add_tree_level
    import add_tree_pkg::*;
#(
    parameter int unsigned IN_CNT = 2,
    parameter int unsigned IN_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [IN_W-1:0]   in_i [IN_CNT-1:0],
    input  logic              valid_i,
    output logic [IN_W:0]     out_o [half_ceil(IN_CNT)-1:0],
    output logic              valid_o
);
    localparam int unsigned OUT_CNT = half_ceil(IN_CNT);

    logic [IN_W:0] sum_d [OUT_CNT-1:0];
    logic [IN_W:0] sum_q [OUT_CNT-1:0];
    logic          valid_q;

    for (genvar i = 0; i < OUT_CNT; i++) begin : g_pair
        if (2 * i + 1 < IN_CNT) begin : g_add
            assign sum_d[i] = {1'b0, in_i[2*i]} + {1'b0, in_i[2*i+1]};
        end else begin : g_pass
            assign sum_d[i] = {1'b0, in_i[2*i]};
        end
    end

    // Level register: data and valid advance together only when enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned j = 32'd0; j < OUT_CNT; j++) begin
                sum_q[j] <= {(IN_W+1){1'b0}};
            end
            valid_q <= 1'b0;
        end else if (en) begin
            for (int unsigned j = 32'd0; j < OUT_CNT; j++) begin
                sum_q[j] <= sum_d[j];
            end
            valid_q <= valid_i;
        end
    end

    assign out_o   = sum_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/add_tree.sv
// ----------------------------------------------------------------------------
// add_tree
// Pipelined unsigned adder tree: sums N operands of WIDTH bits through
// $clog2(N) registered pairwise levels (one register stage when N=1).
// A valid bit is carried alongside so add_tree_valid_out lines up with its sum.
// Ports:
//   clk                - clock, rising edge
//   rst                - asynchronous active-high reset
//   en                 - pipeline advance enable (all stages hold when low)
//   in                 - N unsigned operands, WIDTH bits each
//   add_tree_valid_in  - in[] carries a valid sample
//   add_tree_result    - sum, WIDTH+$clog2(N) bits
//   add_tree_valid_out - add_tree_result is valid
// Build option:
//   ADD_TREE_OUT_REG_EN - when defined, one extra output register follows the
//                         final level (latency +1).
// ----------------------------------------------------------------------------
module add_tree
    import add_tree_pkg::*;
#(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned N     = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [WIDTH-1:0]           in [N-1:0],
    input  logic                       add_tree_valid_in,
    output logic [WIDTH+$clog2(N)-1:0] add_tree_result,
    output logic                       add_tree_valid_out
);
    localparam int unsigned L     = tree_levels(N);
    localparam int unsigned RES_W = WIDTH + L;

    logic [RES_W-1:0] tree_sum_s;
    logic             tree_valid_s;

    if (L == 0) begin : g_single
        // A single operand still gets one register stage.
        logic [RES_W-1:0] sum_q;
        logic             valid_q;

        // Single-stage register for the N=1 build.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sum_q   <= {RES_W{1'b0}};
                valid_q <= 1'b0;
            end else if (en) begin
                sum_q   <= in[0];
                valid_q <= add_tree_valid_in;
            end
        end

        assign tree_sum_s   = sum_q;
        assign tree_valid_s = valid_q;
    end else begin : g_tree
        for (genvar k = 0; k < L; k++) begin : g_lvl
            localparam int unsigned CNT = level_count(N, k);
            localparam int unsigned W   = level_width(WIDTH, k);

            logic [W:0] lvl_out_s [level_count(N, k + 1)-1:0];
            logic       lvl_valid_s;

            if (k == 0) begin : g_first
                add_tree_level #(
                    .IN_CNT (CNT),
                    .IN_W   (W)
                ) u_level (
                    .clk     (clk),
                    .rst     (rst),
                    .en      (en),
                    .in_i    (in),
                    .valid_i (add_tree_valid_in),
                    .out_o   (lvl_out_s),
                    .valid_o (lvl_valid_s)
                );
            end else begin : g_next
                // Each level consumes the registered outputs of the one before.
                add_tree_level #(
                    .IN_CNT (CNT),
                    .IN_W   (W)
                ) u_level (
                    .clk     (clk),
                    .rst     (rst),
                    .en      (en),
                    .in_i    (g_lvl[k-1].lvl_out_s),
                    .valid_i (g_lvl[k-1].lvl_valid_s),
                    .out_o   (lvl_out_s),
                    .valid_o (lvl_valid_s)
                );
            end
        end

        assign tree_sum_s   = g_lvl[L-1].lvl_out_s[0];
        assign tree_valid_s = g_lvl[L-1].lvl_valid_s;
    end

`ifdef ADD_TREE_OUT_REG_EN
    logic [RES_W-1:0] out_result_q;
    logic             out_valid_q;

    // Optional output register after the final tree level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_result_q <= {RES_W{1'b0}};
            out_valid_q  <= 1'b0;
        end else if (en) begin
            out_result_q <= tree_sum_s;
            out_valid_q  <= tree_valid_s;
        end
    end

    assign add_tree_result    = out_result_q;
    assign add_tree_valid_out = out_valid_q;
`else
    assign add_tree_result    = tree_sum_s;
    assign add_tree_valid_out = tree_valid_s;
`endif

endmodule

// File: tb/tb_add_tree.sv
`timescale 1ns/1ps
module tb_add_tree;

`ifdef ADD_TREE_OUT_REG_EN
    localparam int XTRA = 1;
`else
    localparam int XTRA = 0;
`endif
    localparam int LAT5 = 3 + XTRA;
    localparam int LAT8 = 3 + XTRA;
    localparam int LAT1 = 1 + XTRA;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       valid_in;
    logic [5:0] in5 [4:0];
    logic [5:0] in8 [7:0];
    logic [5:0] in1 [0:0];
    logic [8:0] res5;
    logic [8:0] res8;
    logic [5:0] res1;
    logic       v5, v8, v1;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    add_tree #(.WIDTH(6), .N(5)) dut5 (
        .clk(clk), .rst(rst), .en(en), .in(in5),
        .add_tree_valid_in(valid_in), .add_tree_result(res5), .add_tree_valid_out(v5)
    );
    add_tree #(.WIDTH(6), .N(8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .in(in8),
        .add_tree_valid_in(valid_in), .add_tree_result(res8), .add_tree_valid_out(v8)
    );
    add_tree #(.WIDTH(6), .N(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .in(in1),
        .add_tree_valid_in(valid_in), .add_tree_result(res1), .add_tree_valid_out(v1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set5(input int a, input int b, input int c, input int d, input int e);
        in5[0] = 6'(a); in5[1] = 6'(b); in5[2] = 6'(c); in5[3] = 6'(d); in5[4] = 6'(e);
    endtask

    // Directed vectors whose sums are 15 + idx.
    task automatic load_vec(input int idx);
        case (idx)
            0:  set5(1, 2, 3, 4, 5);
            1:  set5(1, 2, 3, 4, 6);
            2:  set5(1, 2, 3, 5, 6);
            3:  set5(1, 2, 4, 5, 6);
            4:  set5(1, 3, 4, 5, 6);
            5:  set5(2, 3, 4, 5, 6);
            6:  set5(2, 3, 4, 5, 7);
            7:  set5(2, 3, 4, 6, 7);
            8:  set5(2, 3, 5, 6, 7);
            9:  set5(2, 4, 5, 6, 7);
            10: set5(3, 4, 5, 6, 7);
            default: set5(0, 0, 0, 0, 0);
        endcase
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; valid_in = 1'b0;
        set5(0, 0, 0, 0, 0);
        for (int j = 0; j < 8; j++) in8[j] = 6'd0;
        in1[0] = 6'd0;
        #3;
        tick(); tick();
        tests_run++;
        if (v5 !== 1'b0 || res5 !== 9'd0) begin
            tests_failed++;
            $display("FAIL reset_n5: valid=%b result=%0d expected valid=0 result=0", v5, res5);
        end
        tests_run++;
        if (v8 !== 1'b0 || res8 !== 9'd0) begin
            tests_failed++;
            $display("FAIL reset_n8: valid=%b result=%0d expected valid=0 result=0", v8, res8);
        end
        tests_run++;
        if (v1 !== 1'b0 || res1 !== 6'd0) begin
            tests_failed++;
            $display("FAIL reset_n1: valid=%b result=%0d expected valid=0 result=0", v1, res1);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        load_vec(0);
        valid_in = 1'b1;
        for (int e = 1; e <= LAT5 + 3; e++) begin
            tick();
            valid_in = 1'b0;
            tests_run++;
            if (v5 !== (e == LAT5)) begin
                tests_failed++;
                $display("FAIL single_valid edge %0d: got %b expected %b", e, v5, (e == LAT5));
            end
            if (e == LAT5) begin
                tests_run++;
                if (res5 !== 9'd15) begin
                    tests_failed++;
                    $display("FAIL single_sum: got %0d expected 15", res5);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int s;
        for (int e = 1; e <= 11 + LAT5 + 3; e++) begin
            if (e - 1 <= 10) begin
                load_vec(e - 1);
                valid_in = 1'b1;
            end else begin
                valid_in = 1'b0;
            end
            tick();
            s = e - LAT5;
            tests_run++;
            if (v5 !== (s >= 0 && s <= 10)) begin
                tests_failed++;
                $display("FAIL b2b_valid edge %0d: got %b expected %b", e, v5, (s >= 0 && s <= 10));
            end
            if (s >= 0 && s <= 10) begin
                tests_run++;
                if (res5 !== 9'(15 + s)) begin
                    tests_failed++;
                    $display("FAIL b2b_sum edge %0d: got %0d expected %0d", e, res5, 15 + s);
                end
            end
        end
    endtask

    task automatic test_max();
        set5(63, 63, 63, 63, 63);
        valid_in = 1'b1;
        for (int e = 1; e <= LAT5 + 1; e++) begin
            tick();
            valid_in = 1'b0;
            if (e == LAT5) begin
                tests_run++;
                if (v5 !== 1'b1 || res5 !== 9'd315) begin
                    tests_failed++;
                    $display("FAIL max_sum: valid=%b result=%0d expected valid=1 result=315", v5, res5);
                end
            end
        end
    endtask

    task automatic test_enable_stall();
        int ec;
        int idx;
        int s;
        logic fed;
        ec = 0; idx = 0;
        for (int e = 1; e <= 15; e++) begin
            if (e == 5 || e == 6) begin
                en = 1'b0;
                set5(63, 63, 63, 63, 63);
                valid_in = 1'b1;
            end else begin
                en = 1'b1;
                if (idx <= 5) begin
                    load_vec(idx);
                    valid_in = 1'b1;
                end else begin
                    valid_in = 1'b0;
                end
            end
            fed = en && (idx <= 5);
            tick();
            if (en) ec++;
            if (fed) idx++;
            s = ec - LAT5;
            tests_run++;
            if (v5 !== (s >= 0 && s <= 5)) begin
                tests_failed++;
                $display("FAIL stall_valid edge %0d: got %b expected %b", e, v5, (s >= 0 && s <= 5));
            end
            if (s >= 0 && s <= 5) begin
                tests_run++;
                if (res5 !== 9'(15 + s)) begin
                    tests_failed++;
                    $display("FAIL stall_sum edge %0d: got %0d expected %0d", e, res5, 15 + s);
                end
            end
        end
        en = 1'b1;
    endtask

    task automatic test_reset_mid();
        for (int e = 1; e <= 5; e++) begin
            load_vec(e - 1);
            valid_in = 1'b1;
            tick();
        end
        tests_run++;
        if (v5 !== 1'b1 || res5 !== 9'(15 + 5 - LAT5)) begin
            tests_failed++;
            $display("FAIL pre_reset: valid=%b result=%0d expected valid=1 result=%0d", v5, res5, 15 + 5 - LAT5);
        end
        valid_in = 1'b0;
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (v5 !== 1'b0 || res5 !== 9'd0) begin
            tests_failed++;
            $display("FAIL async_reset: valid=%b result=%0d expected valid=0 result=0", v5, res5);
        end
        #1 rst = 1'b0;
        for (int e = 1; e <= LAT5 + 2; e++) begin
            tick();
            tests_run++;
            if (v5 !== 1'b0) begin
                tests_failed++;
                $display("FAIL stale_after_reset edge %0d: got valid=%b expected 0", e, v5);
            end
        end
        load_vec(10);
        valid_in = 1'b1;
        for (int e = 1; e <= LAT5 + 1; e++) begin
            tick();
            valid_in = 1'b0;
            tests_run++;
            if (v5 !== (e == LAT5)) begin
                tests_failed++;
                $display("FAIL post_reset_valid edge %0d: got %b expected %b", e, v5, (e == LAT5));
            end
            if (e == LAT5) begin
                tests_run++;
                if (res5 !== 9'd25) begin
                    tests_failed++;
                    $display("FAIL post_reset_sum: got %0d expected 25", res5);
                end
            end
        end
    endtask

    task automatic test_sizes();
        set5(0, 0, 0, 0, 0);
        for (int j = 0; j < 8; j++) in8[j] = 6'(j + 1);
        in1[0] = 6'd42;
        valid_in = 1'b1;
        for (int e = 1; e <= LAT8 + 3; e++) begin
            tick();
            if (e == 1) begin
                for (int j = 0; j < 8; j++) in8[j] = 6'd63;
                in1[0] = 6'd63;
            end else begin
                valid_in = 1'b0;
            end
            tests_run++;
            if (v8 !== (e == LAT8 || e == LAT8 + 1)) begin
                tests_failed++;
                $display("FAIL n8_valid edge %0d: got %b expected %b", e, v8, (e == LAT8 || e == LAT8 + 1));
            end
            if (e == LAT8) begin
                tests_run++;
                if (res8 !== 9'd36) begin
                    tests_failed++;
                    $display("FAIL n8_sum: got %0d expected 36", res8);
                end
            end
            if (e == LAT8 + 1) begin
                tests_run++;
                if (res8 !== 9'd504) begin
                    tests_failed++;
                    $display("FAIL n8_max: got %0d expected 504", res8);
                end
            end
            tests_run++;
            if (v1 !== (e == LAT1 || e == LAT1 + 1)) begin
                tests_failed++;
                $display("FAIL n1_valid edge %0d: got %b expected %b", e, v1, (e == LAT1 || e == LAT1 + 1));
            end
            if (e == LAT1) begin
                tests_run++;
                if (res1 !== 6'd42) begin
                    tests_failed++;
                    $display("FAIL n1_sum: got %0d expected 42", res1);
                end
            end
            if (e == LAT1 + 1) begin
                tests_run++;
                if (res1 !== 6'd63) begin
                    tests_failed++;
                    $display("FAIL n1_max: got %0d expected 63", res1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_max();
        test_enable_stall();
        test_reset_mid();
        test_sizes();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
